// File: rtl/uart_frame_streamer_if.sv
// rtl/uart_frame_streamer_if.sv - pixel-in / uart-out link bundle for uart_frame_streamer
// Signals:
//   frame_sync  1-clk frame start pulse      (master -> slave)
//   canny_de    pixel valid                  (master -> slave)
//   canny_data  8-bit pixel value            (master -> slave)
//   tx          UART serial out, idle high   (slave -> master)
//   busy        capture/send in progress     (slave -> master)
//   frame_sent  1-clk pulse after EOF        (slave -> master)
//   frame_drop  1-clk pulse per lost pixel   (slave -> master)
interface uart_frame_streamer_if;
  logic       frame_sync;
  logic       canny_de;
  logic [7:0] canny_data;
  logic       tx;
  logic       busy;
  logic       frame_sent;
  logic       frame_drop;

  modport master (
    output frame_sync, canny_de, canny_data,
    input  tx, busy, frame_sent, frame_drop
  );

  modport slave (
    input  frame_sync, canny_de, canny_data,
    output tx, busy, frame_sent, frame_drop
  );
endinterface

// File: rtl/uart_frame_streamer.sv
// rtl/uart_frame_streamer.sv - captures one Canny frame to RAM and streams it as a framed 8N1 UART packet
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   link   uart_frame_streamer_if.slave (pixel input, tx / busy / frame_sent / frame_drop outputs)
// Packet: SOF, payload (1 bpp packed or raw byte/px), optional CRC-8, EOF.
// Build option: define FRAME_CRC_EN to append CRC-8 (poly 0x07, init 0x00) over the payload.
module uart_frame_streamer #(
  parameter int          IMG_WIDTH  = 80,
  parameter int          IMG_HEIGHT = 120,
  parameter int          PACK_EN    = 1,
  parameter int          BAUD_DIV   = 868,
  parameter logic [7:0]  SOF_BYTE   = 8'hA5,
  parameter logic [7:0]  EOF_BYTE   = 8'h5A
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_frame_streamer_if.slave  link
);

  localparam int TOTAL_PIXELS  = IMG_WIDTH * IMG_HEIGHT;
  localparam int PAYLOAD_BYTES = (PACK_EN != 0) ? TOTAL_PIXELS / 8 : TOTAL_PIXELS;
  localparam int PX_W          = $clog2(TOTAL_PIXELS + 1);
  localparam int AW            = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int BC_W          = $clog2(PAYLOAD_BYTES + 1);
  localparam int BAUD_W        = $clog2(BAUD_DIV);

  localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(TOTAL_PIXELS - 1);
  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(PAYLOAD_BYTES);
  localparam logic [AW-1:0]     ADDR_LAST = AW'(PAYLOAD_BYTES - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SEND_SOF,
    ST_SEND_DATA,
`ifdef FRAME_CRC_EN
    ST_SEND_CRC,
`endif
    ST_SEND_EOF
  } state_t;

`ifdef FRAME_CRC_EN
  function automatic logic [7:0] crc8_next(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  state_t            state;
  logic [PX_W-1:0]   px_cnt;
  logic [6:0]        pack_reg;
  logic [7:0]        ram [PAYLOAD_BYTES];
  logic [AW-1:0]     rd_addr;
  logic [7:0]        rd_data;
  logic [BC_W-1:0]   byte_cnt;
  logic [7:0]        tx_shift;
  logic [3:0]        bit_idx;      // 0 start, 1..8 data, 9 stop
  logic [BAUD_W-1:0] baud_cnt;
  logic              tx_q;
  logic              busy_q;
  logic              frame_sent_q;
  logic              frame_drop_q;
`ifdef FRAME_CRC_EN
  logic [7:0]        crc;
`endif

  logic              capturing;
  logic              sending;
  logic              accept;
  logic              px_bit;
  logic [PX_W-1:0]   px_idx;
  logic [7:0]        packed_byte;
  logic              ram_we;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;
  logic              byte_done;
  logic              load_en;
  logic [7:0]        load_val;
  logic [AW-1:0]     rd_next;

  always_comb begin
    capturing   = (state == ST_IDLE) || (state == ST_CAPTURE);
    sending     = !capturing;
    accept      = capturing && link.canny_de;
    // frame_sync restarts the frame; a pixel on the same clock becomes pixel 0
    px_idx      = link.frame_sync ? '0 : px_cnt;
    px_bit      = (link.canny_data != 8'd0);
    packed_byte = {pack_reg, px_bit};
    if (PACK_EN != 0) begin
      ram_we  = accept && (px_idx[2:0] == 3'd7);
      wr_addr = AW'(px_idx >> 3);
      wr_data = packed_byte;
    end else begin
      ram_we  = accept;
      wr_addr = AW'(px_idx);
      wr_data = link.canny_data;
    end
    byte_done = sending && (baud_cnt == BAUD_LAST) && (bit_idx == 4'd9);
    rd_next   = (rd_addr == ADDR_LAST) ? '0 : rd_addr + AW'(1);
  end

  // Selects the byte whose start bit begins on the next clock; a new byte is
  // loaded on the same edge the previous stop bit ends, so there is no gap.
  always_comb begin
    load_en  = 1'b0;
    load_val = SOF_BYTE;
    case (state)
      ST_IDLE, ST_CAPTURE: begin
        load_en  = accept && (px_idx == PX_LAST);
        load_val = SOF_BYTE;
      end
      ST_SEND_SOF: begin
        load_en  = byte_done;
        load_val = rd_data;
      end
      ST_SEND_DATA: begin
        load_en = byte_done;
        if (byte_cnt == BC_LAST) begin
`ifdef FRAME_CRC_EN
          load_val = crc;
`else
          load_val = EOF_BYTE;
`endif
        end else begin
          load_val = rd_data;
        end
      end
`ifdef FRAME_CRC_EN
      ST_SEND_CRC: begin
        load_en  = byte_done;
        load_val = EOF_BYTE;
      end
`endif
      default: begin
        load_en  = 1'b0;
        load_val = SOF_BYTE;
      end
    endcase
  end

  // Frame store. rd_data is refreshed every clock from rd_addr, which is
  // advanced one byte ahead of the transmitter so the read latency is hidden.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[wr_addr] <= wr_data;
    end
    rd_data <= ram[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      px_cnt       <= '0;
      pack_reg     <= '0;
      rd_addr      <= '0;
      byte_cnt     <= '0;
      tx_shift     <= '0;
      bit_idx      <= '0;
      baud_cnt     <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_sent_q <= 1'b0;
      frame_drop_q <= 1'b0;
`ifdef FRAME_CRC_EN
      crc          <= 8'h00;
`endif
    end else begin
      frame_sent_q <= 1'b0;
      frame_drop_q <= 1'b0;

      if (accept) begin
        pack_reg <= packed_byte[6:0];
      end

      // Bit timer: counts BAUD_DIV clocks per bit, restarted by every byte load.
      if (sending) begin
        frame_drop_q <= link.canny_de;
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt <= '0;
          if (bit_idx == 4'd8) begin
            tx_q    <= 1'b1;
            bit_idx <= 4'd9;
          end else if (bit_idx != 4'd9) begin
            tx_q     <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            bit_idx  <= bit_idx + 4'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + BAUD_W'(1);
        end
      end

      case (state)
        ST_IDLE, ST_CAPTURE: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (px_idx == PX_LAST) begin
              state   <= ST_SEND_SOF;
              px_cnt  <= '0;
              rd_addr <= '0;
            end else begin
              state  <= ST_CAPTURE;
              px_cnt <= px_idx + PX_W'(1);
            end
          end else if (link.frame_sync) begin
            state  <= ST_CAPTURE;
            px_cnt <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_SEND_SOF: begin
          if (byte_done) begin
            state    <= ST_SEND_DATA;
            byte_cnt <= BC_W'(1);
            rd_addr  <= rd_next;
`ifdef FRAME_CRC_EN
            crc      <= crc8_next(8'h00, rd_data);
`endif
          end
        end
        ST_SEND_DATA: begin
          if (byte_done) begin
            if (byte_cnt == BC_LAST) begin
`ifdef FRAME_CRC_EN
              state <= ST_SEND_CRC;
`else
              state <= ST_SEND_EOF;
`endif
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
              rd_addr  <= rd_next;
`ifdef FRAME_CRC_EN
              crc      <= crc8_next(crc, rd_data);
`endif
            end
          end
        end
`ifdef FRAME_CRC_EN
        ST_SEND_CRC: begin
          if (byte_done) begin
            state <= ST_SEND_EOF;
          end
        end
`endif
        ST_SEND_EOF: begin
          if (byte_done) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_sent_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (load_en) begin
        tx_shift <= load_val;
        tx_q     <= 1'b0;
        bit_idx  <= '0;
        baud_cnt <= '0;
      end
    end
  end

  assign link.tx         = tx_q;
  assign link.busy       = busy_q;
  assign link.frame_sent = frame_sent_q;
  assign link.frame_drop = frame_drop_q;

endmodule
